// File: rtl/arb_sink_downsizer_pkg.sv
// Shared constants, FSM state type and width helpers for the arbiter sink downsizer.
package arb_pkg;

    localparam int unsigned DEF_WIDTH      = 64;
    localparam int unsigned DEF_OUT_WIDTH  = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sinkState_t;

    function automatic int unsigned beatRatio(input int unsigned wordWidth, input int unsigned beatWidth);
        return wordWidth / beatWidth;
    endfunction

    function automatic int unsigned cntWidth(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/arb_sink_downsizer_sync_fifo.sv
// Plain synchronous FIFO without bypass; head data is read straight from storage.
module sync_fifo
    import arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                     CLK,
    input  logic                     SynReset_N,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         headData,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    // Extra MSB on each pointer separates full from empty after wrap.
    always_ff @(posedge CLK) begin
        if (!SynReset_N) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wrPtr[AW-1:0]] <= pushData;
    end

    assign headData = mem[rdPtr[AW-1:0]];
    assign count    = wrPtr - rdPtr;

endmodule

// File: rtl/arb_sink_downsizer.sv
// Buffers arbiter words in a FIFO and serialises each one LSB-first into narrow ready/valid beats.
module arb_sink_downsizer
    import arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic                          CLK,
    input  logic                          SynReset_N,
    input  logic                          i_DataValid,
    input  logic [WIDTH-1:0]              i_DataIn,
    output logic                          o_DataGrant,
    output logic                          o_BeatValid,
    output logic [OUT_WIDTH-1:0]          o_BeatData,
    output logic                          o_BeatFirst,
    output logic                          o_BeatLast,
    input  logic                          i_BeatReady,
    output logic [$clog2(FIFO_DEPTH):0]   o_Level
);

    localparam int unsigned RATIO = beatRatio(WIDTH, OUT_WIDTH);
    localparam int unsigned CW    = cntWidth(RATIO);
    localparam int unsigned LW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(RATIO - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if ((WIDTH % OUT_WIDTH) != 0 || (WIDTH / OUT_WIDTH) < 2) begin : gBadRatio
        $error("WIDTH must be a multiple of OUT_WIDTH with a ratio of at least 2");
    end

    sinkState_t                   state, stateNext;
    logic [CW-1:0]                cnt, cntNext;
    logic [WIDTH-1:0]             stage;
    logic [WIDTH-1:0]             headData;
    logic [RATIO-1:0][OUT_WIDTH-1:0] stageBeats;
    logic                         push, pop, fifoNonEmpty;

    assign o_DataGrant  = (o_Level < LVL_FULL);
    assign push         = i_DataValid && o_DataGrant;
    assign fifoNonEmpty = (o_Level != '0);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WIDTH)
    ) uFifo (
        .CLK        (CLK),
        .SynReset_N (SynReset_N),
        .push       (push),
        .pushData   (i_DataIn),
        .pop        (pop),
        .headData   (headData),
        .count      (o_Level)
    );

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (fifoNonEmpty) begin
                    pop       = 1'b1;
                    cntNext   = '0;
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (i_BeatReady) begin
                    if (cnt != CNT_LAST) begin
                        cntNext = cnt + 1'b1;
                    end else if (fifoNonEmpty) begin
                        // Reload on the last beat so consecutive words stream without a bubble.
                        pop     = 1'b1;
                        cntNext = '0;
                    end else begin
                        cntNext   = '0;
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!SynReset_N) begin
            state <= IDLE;
            cnt   <= '0;
            stage <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (pop) stage <= headData;
        end
    end

    assign stageBeats  = stage;
    assign o_BeatValid = (state == SEND);
    assign o_BeatData  = o_BeatValid ? stageBeats[cnt] : '0;
    assign o_BeatFirst = o_BeatValid && (cnt == '0);
    assign o_BeatLast  = o_BeatValid && (cnt == CNT_LAST);

endmodule

// File: tb/tb_arb_sink_downsizer.sv
// Directed bench for arb_sink_downsizer: a cycle table plus scoreboarded multi-cycle sequences.
module tb_arb_sink_downsizer;

    logic        CLK = 1'b0;
    logic        SynReset_N = 1'b0;
    logic        i_DataValid = 1'b0;
    logic [63:0] i_DataIn = '0;
    logic        o_DataGrant;
    logic        o_BeatValid;
    logic [15:0] o_BeatData;
    logic        o_BeatFirst;
    logic        o_BeatLast;
    logic        i_BeatReady = 1'b1;
    logic [3:0]  o_Level;

    always #5 CLK = ~CLK;

    arb_sink_downsizer #(
        .FIFO_DEPTH (8),
        .WIDTH      (64),
        .OUT_WIDTH  (16)
    ) dut (
        .CLK         (CLK),
        .SynReset_N  (SynReset_N),
        .i_DataValid (i_DataValid),
        .i_DataIn    (i_DataIn),
        .o_DataGrant (o_DataGrant),
        .o_BeatValid (o_BeatValid),
        .o_BeatData  (o_BeatData),
        .o_BeatFirst (o_BeatFirst),
        .o_BeatLast  (o_BeatLast),
        .i_BeatReady (i_BeatReady),
        .o_Level     (o_Level)
    );

    typedef struct {
        logic        rstN;
        logic        valid;
        logic [63:0] data;
        logic        ready;
        logic        eValid;
        logic [15:0] eData;
        logic        eFirst;
        logic        eLast;
        logic        eGrant;
        logic [3:0]  eLevel;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic        f;
        logic        l;
    } beat_t;

    vec_t        tbl[7];
    beat_t       expQ[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned wordIdx = 1;
    int unsigned accepted = 0;
    int unsigned beatCount = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] makeWord(input int unsigned k);
        logic [7:0] t;
        t = k[7:0];
        return {t, 8'hD3, t, 8'hC2, t, 8'hB1, t, 8'hA0};
    endfunction

    // One clock: drive inputs, score any push/beat transfer, then check stall stability.
    task automatic tick(input logic rstN, input logic valid, input logic ready);
        logic        acc, xfer, stall;
        logic [15:0] sd;
        logic        sf, sl;
        logic [63:0] w;
        beat_t       b;
        w           = makeWord(wordIdx);
        SynReset_N  = rstN;
        i_DataValid = valid;
        i_DataIn    = w;
        i_BeatReady = ready;
        acc   = rstN && valid && o_DataGrant;
        xfer  = rstN && o_BeatValid && ready;
        stall = rstN && o_BeatValid && !ready;
        sd = o_BeatData;
        sf = o_BeatFirst;
        sl = o_BeatLast;
        if (xfer) begin
            beatCount++;
            if (expQ.size() == 0) begin
                chk("unexpectedBeat", 64'(o_BeatData), 64'hDEAD);
            end else begin
                b = expQ.pop_front();
                chk("beatData", 64'(o_BeatData), 64'(b.d));
                chk("beatFirst", 64'(o_BeatFirst), 64'(b.f));
                chk("beatLast", 64'(o_BeatLast), 64'(b.l));
            end
        end
        if (acc) begin
            for (int unsigned j = 0; j < 4; j++) begin
                b.d = w[j*16 +: 16];
                b.f = (j == 0);
                b.l = (j == 3);
                expQ.push_back(b);
            end
            wordIdx++;
            accepted++;
        end
        @(posedge CLK);
        #1;
        if (!rstN) expQ.delete();
        if (stall) begin
            chk("stallValid", 64'(o_BeatValid), 64'd1);
            chk("stallData", 64'(o_BeatData), 64'(sd));
            chk("stallFirst", 64'(o_BeatFirst), 64'(sf));
            chk("stallLast", 64'(o_BeatLast), 64'(sl));
        end
    endtask

    task automatic drain(input logic readyInit, input bit toggle, input int unsigned bound);
        logic        r;
        int unsigned n;
        r = readyInit;
        n = 0;
        while (expQ.size() > 0 && n < bound) begin
            tick(1'b1, 1'b0, r);
            if (toggle) r = ~r;
            n++;
        end
        chk("drainLeft", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b0, a0, gap, n;

        tbl[0] = '{1'b0, 1'b0, 64'h0, 1'b1,                   1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 4'd0};
        tbl[1] = '{1'b1, 1'b1, 64'h4444_3333_2222_1111, 1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 4'd1};
        tbl[2] = '{1'b1, 1'b0, 64'h0, 1'b1,                   1'b1, 16'h1111, 1'b1, 1'b0, 1'b1, 4'd0};
        tbl[3] = '{1'b1, 1'b0, 64'h0, 1'b1,                   1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[4] = '{1'b1, 1'b0, 64'h0, 1'b1,                   1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[5] = '{1'b1, 1'b0, 64'h0, 1'b1,                   1'b1, 16'h4444, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[6] = '{1'b1, 1'b0, 64'h0, 1'b1,                   1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 4'd0};

        for (int i = 0; i < 7; i++) begin
            SynReset_N  = tbl[i].rstN;
            i_DataValid = tbl[i].valid;
            i_DataIn    = tbl[i].data;
            i_BeatReady = tbl[i].ready;
            @(posedge CLK);
            #1;
            chk($sformatf("tbl%0d.valid", i), 64'(o_BeatValid), 64'(tbl[i].eValid));
            chk($sformatf("tbl%0d.data", i),  64'(o_BeatData),  64'(tbl[i].eData));
            chk($sformatf("tbl%0d.first", i), 64'(o_BeatFirst), 64'(tbl[i].eFirst));
            chk($sformatf("tbl%0d.last", i),  64'(o_BeatLast),  64'(tbl[i].eLast));
            chk($sformatf("tbl%0d.grant", i), 64'(o_DataGrant), 64'(tbl[i].eGrant));
            chk($sformatf("tbl%0d.level", i), 64'(o_Level),     64'(tbl[i].eLevel));
        end

        // Three back-to-back words must stream 12 beats with no gap.
        b0  = beatCount;
        gap = 0;
        for (int i = 0; i < 3; i++) begin
            if (beatCount > b0 && expQ.size() > 0 && !o_BeatValid) gap++;
            tick(1'b1, 1'b1, 1'b1);
        end
        n = 0;
        while (expQ.size() > 0 && n < 30) begin
            if (beatCount > b0 && !o_BeatValid) gap++;
            tick(1'b1, 1'b0, 1'b1);
            n++;
        end
        chk("b2bBeats", 64'(beatCount - b0), 64'd12);
        chk("b2bGaps", 64'(gap), 64'd0);
        chk("b2bIdle", 64'(o_BeatValid), 64'd0);

        // Ready toggling mid-word.
        tick(1'b1, 1'b1, 1'b1);
        b0 = beatCount;
        drain(1'b1, 1'b1, 30);
        chk("toggleBeats", 64'(beatCount - b0), 64'd4);

        // Fill under stall: 1 staged + 8 buffered, then grant drops.
        a0 = accepted;
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0);
        chk("fullAccepted", 64'(accepted - a0), 64'd9);
        chk("fullLevel", 64'(o_Level), 64'd8);
        chk("fullGrant", 64'(o_DataGrant), 64'd0);
        b0 = beatCount;
        drain(1'b1, 1'b0, 60);
        chk("fullBeats", 64'(beatCount - b0), 64'd36);
        chk("fullEmptyLevel", 64'(o_Level), 64'd0);

        // Reset mid-word with cnt=2 and 3 words buffered.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        chk("preRstLevel", 64'(o_Level), 64'd3);
        chk("preRstData", 64'(o_BeatData), 64'(makeWord(wordIdx - 4) >> 32) & 64'hFFFF);
        tick(1'b0, 1'b0, 1'b1);
        chk("rstValid", 64'(o_BeatValid), 64'd0);
        chk("rstLevel", 64'(o_Level), 64'd0);
        chk("rstGrant", 64'(o_DataGrant), 64'd1);
        tick(1'b1, 1'b1, 1'b1);
        drain(1'b1, 1'b0, 20);

        // Push and pop on the same edge at level 4.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
        chk("lvl4Before", 64'(o_Level), 64'd4);
        chk("lvl4LastBeat", 64'(o_BeatLast), 64'd1);
        tick(1'b1, 1'b1, 1'b1);
        chk("lvl4After", 64'(o_Level), 64'd4);
        chk("lvl4First", 64'(o_BeatFirst), 64'd1);
        drain(1'b1, 1'b0, 40);
        chk("endValid", 64'(o_BeatValid), 64'd0);
        chk("endLevel", 64'(o_Level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
